// File: rtl/pdm_mic_rx_pkg.sv
// Shared audio constants and the ones-count to PCM scaling helper.
package pdm_mic_rx_pkg;

    localparam int PCM_W     = 8;
    localparam int ACC_MAX_W = 13;

    // A full window of ones (count == 2^decim_log2) saturates to full scale.
    function automatic logic [PCM_W-1:0] pcm_scale(input logic [ACC_MAX_W-1:0] ones,
                                                   input int                   decim_log2);
        logic [ACC_MAX_W-1:0] shifted;
        if (ones >= (ACC_MAX_W'(1) << decim_log2)) begin
            return '1;
        end
        shifted = ones >> (decim_log2 - PCM_W);
        return shifted[PCM_W-1:0];
    endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM bit clock generator: divides clk into mclk and flags each mclk rising edge.
module pdm_clk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic mclk,
    output logic rise_evt
);

    localparam logic [7:0] TERM_CNT = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            mclk     <= 1'b0;
            rise_evt <= 1'b0;
        end else if (!en) begin
            div_cnt  <= '0;
            mclk     <= 1'b0;
            rise_evt <= 1'b0;
        end else if (div_cnt == TERM_CNT) begin
            div_cnt  <= '0;
            mclk     <= ~mclk;
            // Registered alongside mclk so the pulse lines up with the 0->1 edge.
            rise_evt <= ~mclk;
        end else begin
            div_cnt  <= div_cnt + 8'd1;
            rise_evt <= 1'b0;
        end
    end

endmodule

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: boxcar decimation of micData to 8-bit PCM with a one-entry output buffer.
module pdm_mic_rx
    import pdm_mic_rx_pkg::*;
#(
    parameter int CLK_DIV    = 25,
    parameter int DECIM_LOG2 = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             mclk,
    input  logic             micData,
    output logic [PCM_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int ACC_W = DECIM_LOG2 + 1;

    logic [1:0]            sync_q;
    logic                  rise_evt;
    logic [DECIM_LOG2-1:0] bit_cnt;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_sum;
    logic                  win_end;
    logic [PCM_W-1:0]      result;

    pdm_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mclk     (mclk),
        .rise_evt (rise_evt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], micData};
        end
    end

    assign acc_sum = acc + ACC_W'(sync_q[1]);
    assign win_end = en && rise_evt && (bit_cnt == '1);
    assign result  = pcm_scale(ACC_MAX_W'(acc_sum), DECIM_LOG2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else if (!en) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else if (rise_evt) begin
            // The final bit is folded into result, so the next window starts empty.
            if (win_end) begin
                acc     <= '0;
                bit_cnt <= '0;
            end else begin
                acc     <= acc_sum;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (win_end) begin
            dout       <= result;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (win_end && dout_valid && !dout_ready) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule
